// File: rtl/log_pkg.sv
// Shared types and constants for the ln() Taylor-series multicycle unit.
package log_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NORM = 3'd1,
        S_SQ   = 3'd2,
        S_CUBE = 3'd3,
        S_SUM  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [7:0]  LN2     = 8'd177;
    localparam logic [7:0]  INV3    = 8'd85;
    localparam logic [11:0] SAT_POS = 12'h7FF;
    localparam logic [11:0] SAT_NEG = 12'h800;

endpackage

// File: rtl/mul_8x8_unsigned.sv
// Combinational 8x8 unsigned multiplier, shared between the SQ and CUBE steps.
module mul_8x8_unsigned (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    assign p = {8'd0, a} * {8'd0, b};

endmodule

// File: rtl/log_taylor_mc.sv
// Multicycle ln(x): normalise to 2^k*(1+f), then ln(1+f) ~ f - f^2/2 + f^3/3.
module log_taylor_mc
    import log_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] iData,
    input  logic        iDataValid,
    output logic        iReady,
    output logic [11:0] oData,
    output logic        oDataValid
);

    state_t      state_q, state_d;
    logic [19:0] op_q, op_d;
    logic [4:0]  k_q, k_d;
    logic [7:0]  f_q, f_d;
    logic [7:0]  f2_q, f2_d;
    logic [7:0]  f3_q, f3_d;
    logic [11:0] odata_q, odata_d;

    logic [7:0]  mul_a;
    logic [15:0] mul_p;
    logic [4:0]  lead_p;
    logic [7:0]  frac;
    logic signed [15:0] ln2_term;
    logic signed [15:0] t;
    int          idx;

    // Operand is f^2 during CUBE, f during SQ; other input is always f.
    assign mul_a = (state_q == S_CUBE) ? f2_q : f_q;

    mul_8x8_unsigned u_mul (
        .a (mul_a),
        .b (f_q),
        .p (mul_p)
    );

    always_comb begin
        lead_p = '0;
        frac   = '0;
        idx    = 0;
        for (int i = 0; i < 20; i++) begin
            if (op_q[i]) lead_p = 5'(i);
        end
        for (int j = 0; j < 8; j++) begin
            idx = int'(lead_p) - 1 - j;
            if (idx >= 0) frac[7-j] = op_q[5'(idx)];
        end
    end

    always_comb begin
        ln2_term = $signed({{11{k_q[4]}}, k_q}) * $signed({8'd0, LN2});
        t = $signed({8'd0, f_q})
          - $signed({9'd0, f2_q[7:1]})
          + $signed(16'(({8'd0, f3_q} * {8'd0, INV3}) >> 8))
          + ln2_term;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        k_d     = k_q;
        f_d     = f_q;
        f2_d    = f2_q;
        f3_d    = f3_q;
        odata_d = odata_q;
        unique case (state_q)
            S_IDLE: begin
                if (iDataValid) begin
                    op_d    = iData;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (op_q == '0) begin
                    odata_d = SAT_NEG;
                    state_d = S_DONE;
                end else begin
                    k_d     = lead_p - 5'd4;
                    f_d     = frac;
                    state_d = S_SQ;
                end
            end
            S_SQ: begin
                f2_d    = 8'(mul_p >> 8);
                state_d = S_CUBE;
            end
            S_CUBE: begin
                f3_d    = 8'(mul_p >> 8);
                state_d = S_SUM;
            end
            S_SUM: begin
                if (t > 16'sd2047)       odata_d = SAT_POS;
                else if (t < -16'sd2048) odata_d = SAT_NEG;
                else                     odata_d = t[11:0];
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            k_q     <= '0;
            f_q     <= '0;
            f2_q    <= '0;
            f3_q    <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            k_q     <= k_d;
            f_q     <= f_d;
            f2_q    <= f2_d;
            f3_q    <= f3_d;
            odata_q <= odata_d;
        end
    end

    assign iReady     = (state_q == S_IDLE);
    assign oDataValid = (state_q == S_DONE);
    assign oData      = odata_q;

endmodule

// File: tb/tb_log_taylor_mc.sv
// Scoreboard bench for log_taylor_mc: directed ln() points, drops and resets.
module tb_log_taylor_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] iData = '0;
    logic        iDataValid = 1'b0;
    logic        iReady;
    logic [11:0] oData;
    logic        oDataValid;

    int tests = 0;
    int fails = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    log_taylor_mc dut (
        .clk        (clk),
        .rst        (rst),
        .iData      (iData),
        .iDataValid (iDataValid),
        .iReady     (iReady),
        .oData      (oData),
        .oDataValid (oDataValid)
    );

    // Reference arithmetic for the truncated Taylor approximation.
    function automatic logic [11:0] model(input logic [19:0] x);
        int p, k, f, f2, f3, t;
        if (x == 0) return 12'h800;
        p = 0;
        for (int i = 0; i < 20; i++) if (x[i]) p = i;
        k = p - 4;
        f = 0;
        for (int j = 1; j <= 8; j++) begin
            f = f << 1;
            if (p - j >= 0 && x[p-j]) f = f | 1;
        end
        f2 = (f * f) / 256;
        f3 = (f2 * f) / 256;
        t  = f - f2 / 2 + (f3 * 85) / 256 + k * 177;
        if (t > 2047) return 12'h7FF;
        if (t < -2048) return 12'h800;
        return 12'(t);
    endfunction

    task automatic run_op(input logic [19:0] d, input string name);
        int cyc;
        int lat;
        logic [11:0] e;
        @(negedge clk);
        tests++;
        if (iReady !== 1'b1) begin
            fails++;
            $display("FAIL %s ready: got %b want 1", name, iReady);
        end
        iData = d;
        iDataValid = 1'b1;
        exp_q.push_back(model(d));
        lat = (d == 0) ? 2 : 5;
        @(negedge clk);
        iDataValid = 1'b0;
        iData = 20'($urandom);
        cyc = 1;
        while (oDataValid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        e = exp_q.pop_front();
        tests++;
        if (oDataValid !== 1'b1 || cyc != lat) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
        end
        tests++;
        if (oData !== e) begin
            fails++;
            $display("FAIL %s data: got %h want %h", name, oData, e);
        end
        @(negedge clk);
        tests++;
        if (oDataValid !== 1'b0 || oData !== e) begin
            fails++;
            $display("FAIL %s hold: valid %b data %h want 0/%h",
                     name, oDataValid, oData, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (oData !== 12'h000 || oDataValid !== 1'b0) begin
            fails++;
            $display("FAIL reset: data %h valid %b want 000/0", oData, oDataValid);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (iReady !== 1'b1) begin
            fails++;
            $display("FAIL reset ready: got %b want 1", iReady);
        end
    endtask

    task automatic test_vectors();
        run_op(20'h00010, "one");
        run_op(20'h00020, "two");
        run_op(20'h00018, "one_half");
        run_op(20'h00001, "sixteenth");
        run_op(20'h00000, "zero");
        run_op(20'hFFFFF, "max_sat");
        for (int i = 0; i < 6; i++) run_op(20'($urandom), "random");
    endtask

    task automatic test_drop();
        int pulses;
        int rdy_hi;
        logic [11:0] e;
        @(negedge clk);
        iData = 20'h00020;
        iDataValid = 1'b1;
        exp_q.push_back(model(20'h00020));
        @(negedge clk);
        iDataValid = 1'b0;
        pulses = 0;
        rdy_hi = 0;
        e = 12'h000;
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin
                iData = 20'h00010;
                iDataValid = 1'b1;
            end else begin
                iDataValid = 1'b0;
            end
            if (iReady) rdy_hi++;
            if (oDataValid) begin
                pulses++;
                e = exp_q.pop_front();
                tests++;
                if (oData !== e) begin
                    fails++;
                    $display("FAIL drop data: got %h want %h", oData, e);
                end
            end
            @(negedge clk);
        end
        iDataValid = 1'b0;
        tests++;
        if (pulses != 1 || rdy_hi != 0) begin
            fails++;
            $display("FAIL drop pulses: got %0d ready %0d want 1/0", pulses, rdy_hi);
        end
        run_op(20'h00018, "after_drop");
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        iData = 20'h00020;
        iDataValid = 1'b1;
        @(negedge clk);
        iDataValid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (oData !== 12'h000 || oDataValid !== 1'b0 || iReady !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: data %h valid %b ready %b want 000/0/1",
                     oData, oDataValid, iReady);
        end
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (oDataValid) pulses++;
            @(negedge clk);
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL reset_mid pulses: got %0d want 0", pulses);
        end
        run_op(20'h00020, "after_reset");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/log_taylor_mc.md
LOG_TAYLOR_MC -- requirements
Module: log_taylor_mc

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port iData, input, 20 bits: unsigned operand, format {16 integer, 4 fraction}.
REQ-004 SHALL have port iDataValid, input, 1 bit: operand-present strobe.
REQ-005 SHALL have port iReady, output, 1 bit: high only when an operand can be accepted.
REQ-006 SHALL have port oData, output, 12 bits: ln(iData), signed two's complement, format {4 integer, 8 fraction}.
REQ-007 SHALL have port oDataValid, output, 1 bit: one-cycle result strobe.

Function
REQ-008 SHALL accept an operand on a rising edge where iDataValid=1 and iReady=1; iDataValid while iReady=0 SHALL be ignored and dropped.
REQ-009 SHALL run FSM states IDLE -> NORM -> SQ -> CUBE -> SUM -> DONE -> IDLE, one cycle per state; IDLE holds until accept; iReady=1 only in IDLE.
REQ-010 SHALL assert oDataValid for exactly the one cycle the FSM is in DONE, i.e. 5 cycles after the accepting edge; throughput is 1 result per 6 cycles.
REQ-011 NORM: p = position of leading one of the operand (0..19); k = p-4 (signed, -4..15); f = 8 bits immediately below the leading one, left-aligned, zero-padded when p<8.
REQ-012 NORM with operand = 0: skip to DONE with oData = 12'h800 (saturated -8.0).
REQ-013 SQ: f2 = (f*f)>>8, 8 bits, truncated.
REQ-014 CUBE: f3 = (f2*f)>>8, 8 bits, truncated.
REQ-015 SUM: t = f - (f2>>1) + ((f3*85)>>8) + k*177, evaluated in at least 14-bit signed; 177 = ln2 and 85 = 1/3, both in 8-bit fraction.
REQ-016 SUM SHALL saturate: t > 2047 -> 12'h7FF; t < -2048 -> 12'h800; otherwise oData = t[11:0].
REQ-017 oData SHALL be registered, loaded on the SUM->DONE transition (or the NORM->DONE transition for a zero operand), and held until the next load.
REQ-018 Operand SHALL be captured into an internal register on accept; later changes to iData SHALL NOT affect the in-flight result.

Reset
REQ-019 While rst=1: FSM = IDLE, oData = 0, oDataValid = 0, iReady = 1 from the first cycle after rst deasserts.
REQ-020 Reset mid-operation SHALL discard the in-flight operand; no oDataValid SHALL be produced for it.

Structure
REQ-021 Shared package log_pkg SHALL hold the FSM state enum, LN2 = 8'd177, INV3 = 8'd85, SAT_POS = 12'h7FF and SAT_NEG = 12'h800.
REQ-022 A single combinational sub-module mul_8x8_unsigned (8x8 -> 16) SHALL be instantiated once and time-shared between SQ and CUBE.
REQ-023 Leading-one detection and alignment SHALL be combinational within NORM; no additional pipeline registers.

Verification
REQ-024 iData=20'h00010 (1.0) -> oData=12'h000, oDataValid 5 cycles after accept.
REQ-025 iData=20'h00020 (2.0) -> 12'h0B1; iData=20'h00018 (1.5) -> f=128, f2=64, f3=32 -> 12'h06A.
REQ-026 iData=20'h00001 (0.0625) -> k=-4 -> 12'hD3C; iData=20'h00000 -> 12'h800.
REQ-027 iData=20'hFFFFF -> t=2867 -> saturated 12'h7FF.
REQ-028 Second iDataValid 2 cycles after accept -> ignored, iReady=0 throughout, exactly one oDataValid; new operand accepted on the cycle after DONE.
REQ-029 rst pulsed in CUBE -> no oDataValid, oData=0, iReady=1 on the next cycle; the following operand 20'h00020 -> 12'h0B1.
